// File: rtl/eth_rx_ctrl_if.sv
// Byte-stream, filter, buffer and CPU-handshake signals of the Ethernet receive controller.
// The controller connects through the slave modport and its stimulus side through master.
interface eth_rx_ctrl_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_end;
  logic        frame_err;
  logic        promisc;
  logic        n_inhibit;
  logic        n_ss;
  logic [3:0]  filt_a;
  logic        n_recv_buf_we;
  logic        buf_we;
  logic [10:0] buf_addr;
  logic [7:0]  buf_data;
  logic        frame_ready;
  logic [10:0] frame_len;
  logic        frame_ack;
  logic [7:0]  drop_cnt;

  modport slave (
    input  byte_valid, byte_data, frame_end, frame_err, promisc, n_inhibit, frame_ack,
    output n_ss, filt_a, n_recv_buf_we, buf_we, buf_addr, buf_data,
           frame_ready, frame_len, drop_cnt
  );

  modport master (
    output byte_valid, byte_data, frame_end, frame_err, promisc, n_inhibit, frame_ack,
    input  n_ss, filt_a, n_recv_buf_we, buf_we, buf_addr, buf_data,
           frame_ready, frame_len, drop_cnt
  );
endinterface

// File: rtl/eth_rx_ctrl.sv
// Ethernet receive controller: writes accepted frame bytes to the buffer, applies the MAC
// filter and length limits, hands complete frames to the CPU and counts dropped frames.
module eth_rx_ctrl #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 14
) (
  input  logic          clk,
  input  logic          rst,
  eth_rx_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECV, DROP, HOLD} state_t;

  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);

  state_t      state, state_nx;
  logic [10:0] idx, idx_nx;
  logic        skip, skip_nx;
  logic        frame_ready, ready_nx;
  logic [10:0] frame_len, len_nx;
  logic [7:0]  drop_cnt;
  logic        drop_inc;
  logic        wr;
  logic [10:0] cur_idx;
  logic [11:0] length;
  logic        mac_reject, len_reject;
  logic        in_ovr, ovr_done;
  logic        n_ss, n_recv_buf_we, buf_we;
  logic [3:0]  filt_a;
  logic [10:0] buf_addr;
  logic [7:0]  buf_data;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    skip_nx  = skip;
    ready_nx = frame_ready;
    len_nx   = frame_len;
    drop_inc = 1'b0;
    wr       = 1'b0;

    // The first byte of a frame arrives in IDLE, where idx is always zero.
    cur_idx    = (state == IDLE) ? 11'd0 : idx;
    length     = {1'b0, cur_idx} + 12'd1;
    mac_reject = (cur_idx == 11'd6) && !bus.n_inhibit && !bus.promisc;
    len_reject = ({1'b0, cur_idx} >= MAX_L);
    in_ovr     = skip || bus.byte_valid;
    ovr_done   = in_ovr && ((bus.byte_valid && bus.frame_end) || bus.frame_err);

    case (state)
      IDLE, RECV: begin
        if (state == RECV && bus.frame_err) begin
          state_nx = IDLE;
          idx_nx   = 11'd0;
          drop_inc = 1'b1;
        end else if (bus.byte_valid) begin
          if (mac_reject || len_reject) begin
            state_nx = bus.frame_end ? IDLE : DROP;
            idx_nx   = 11'd0;
            drop_inc = bus.frame_end;
          end else begin
            wr = 1'b1;
            if (bus.frame_end) begin
              idx_nx = 11'd0;
              if (length < MIN_L) begin
                state_nx = IDLE;
                drop_inc = 1'b1;
              end else begin
                state_nx = HOLD;
                ready_nx = 1'b1;
                len_nx   = length[10:0];
              end
            end else begin
              state_nx = RECV;
              idx_nx   = cur_idx + 11'd1;
            end
          end
        end
      end
      DROP: begin
        if ((bus.byte_valid && bus.frame_end) || bus.frame_err) begin
          state_nx = IDLE;
          drop_inc = 1'b1;
        end
      end
      HOLD: begin
        // An overrun frame still in progress at ack time finishes in DROP, which counts it.
        if (ovr_done) begin
          skip_nx  = 1'b0;
          drop_inc = 1'b1;
        end else begin
          skip_nx = in_ovr;
        end
        if (bus.frame_ack) begin
          ready_nx = 1'b0;
          state_nx = skip_nx ? DROP : IDLE;
          skip_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 11'd0;
      skip          <= 1'b0;
      frame_ready   <= 1'b0;
      frame_len     <= 11'd0;
      drop_cnt      <= 8'd0;
      n_ss          <= 1'b1;
      n_recv_buf_we <= 1'b1;
      buf_we        <= 1'b0;
      buf_addr      <= 11'd0;
      buf_data      <= 8'd0;
      filt_a        <= 4'd0;
    end else begin
      state         <= state_nx;
      idx           <= idx_nx;
      skip          <= skip_nx;
      frame_ready   <= ready_nx;
      frame_len     <= len_nx;
      n_ss          <= (state_nx != RECV);
      n_recv_buf_we <= !wr;
      buf_we        <= wr;
      if (wr) begin
        buf_addr <= cur_idx;
        buf_data <= bus.byte_data;
        filt_a   <= cur_idx[3:0];
      end
      if (drop_inc && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign bus.n_ss          = n_ss;
  assign bus.filt_a        = filt_a;
  assign bus.n_recv_buf_we = n_recv_buf_we;
  assign bus.buf_we        = buf_we;
  assign bus.buf_addr      = buf_addr;
  assign bus.buf_data      = buf_data;
  assign bus.frame_ready   = frame_ready;
  assign bus.frame_len     = frame_len;
  assign bus.drop_cnt      = drop_cnt;

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Scoreboard bench for eth_rx_ctrl: a frame-level model queues the expected buffer writes and
// frame lengths, and a monitor compares them whenever the controller writes or raises frame_ready.
module tb_eth_rx_ctrl;
  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_rx_ctrl_if bus();

  eth_rx_ctrl #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  int          exp_len_q[$];
  int          exp_drops = 0;
  bit          pending   = 1'b0;
  bit          prev_ready = 1'b0;
  logic [10:0] mon_addr;
  logic [7:0]  mon_data;
  int          mon_len;

  task automatic check_output(string name, int actual, int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int sat_drops();
    return (exp_drops > 255) ? 255 : exp_drops;
  endfunction

  // Monitor: every buffer write and every new frame_ready is matched against the model's queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (bus.buf_we) begin
        if (exp_addr_q.size() == 0) begin
          check_output("unexpected_write", int'(bus.buf_addr), -1);
        end else begin
          mon_addr = exp_addr_q.pop_front();
          mon_data = exp_data_q.pop_front();
          check_output("buf_addr", int'(bus.buf_addr), int'(mon_addr));
          check_output("buf_data", int'(bus.buf_data), int'(mon_data));
          check_output("filt_a", int'(bus.filt_a), int'(mon_addr[3:0]));
          check_output("n_recv_buf_we", int'(bus.n_recv_buf_we), 0);
        end
      end
      if (bus.frame_ready && !prev_ready) begin
        if (exp_len_q.size() == 0) begin
          check_output("unexpected_frame_ready", int'(bus.frame_len), -1);
        end else begin
          mon_len = exp_len_q.pop_front();
          check_output("frame_len", int'(bus.frame_len), mon_len);
        end
      end
      prev_ready = bus.frame_ready;
    end
  end

  task automatic drive_strobe(bit bv, logic [7:0] d, bit fe, bit fer);
    @(posedge clk); #1;
    bus.byte_valid = bv;
    bus.byte_data  = d;
    bus.frame_end  = fe;
    bus.frame_err  = fer;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    bus.frame_end  = 1'b0;
    bus.frame_err  = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // err_at > 0: frame_err strobe replaces byte err_at; err_with_end: last byte carries frame_err too.
  task automatic apply_stimulus(int len, bit inh, bit prom, int err_at, bit err_with_end, bit no_end);
    logic [7:0] payload[];
    int  nbytes, lim;
    bit  mac_rej, ok, was_pending;
    payload = new[len];
    foreach (payload[i]) payload[i] = 8'($urandom);
    nbytes = (err_at > 0) ? err_at : len;
    bus.n_inhibit = inh;
    bus.promisc   = prom;
    was_pending   = pending;
    lim = 0;
    if (was_pending) begin
      if (!no_end) exp_drops++;
    end else begin
      lim     = err_with_end ? len - 1 : nbytes;
      mac_rej = !inh && !prom && (nbytes > 6);
      if (mac_rej && lim > 6) lim = 6;
      if (lim > MAX_LEN) lim = MAX_LEN;
      ok = !no_end && (err_at <= 0) && !err_with_end && !mac_rej &&
           (len <= MAX_LEN) && (len >= MIN_LEN);
      for (int i = 0; i < lim; i++) begin
        exp_addr_q.push_back(11'(i));
        exp_data_q.push_back(payload[i]);
      end
      if (ok) begin
        pending = 1'b1;
        exp_len_q.push_back(len);
      end else if (!no_end) begin
        exp_drops++;
      end
    end
    for (int i = 0; i < nbytes; i++) begin
      drive_strobe(1'b1, payload[i], (i == len - 1) && !no_end, (i == len - 1) && err_with_end);
      if (i == 1 && !was_pending && lim > 1 && i != len - 1) begin
        #1;
        check_output("n_ss_in_frame", int'(bus.n_ss), 0);
      end
    end
    if (err_at > 0) drive_strobe(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    if (!no_end) begin
      check_output("frame_ready", int'(bus.frame_ready), int'(pending));
      check_output("drop_cnt", int'(bus.drop_cnt), sat_drops());
      check_output("n_ss_after", int'(bus.n_ss), 1);
    end
  endtask

  task automatic do_ack();
    @(posedge clk); #1;
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
    pending = 1'b0;
    check_output("ack_clears_ready", int'(bus.frame_ready), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pending   = 1'b0;
    exp_drops = 0;
    exp_len_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    check_output("rst_n_ss", int'(bus.n_ss), 1);
    check_output("rst_n_recv_buf_we", int'(bus.n_recv_buf_we), 1);
    check_output("rst_buf_we", int'(bus.buf_we), 0);
    check_output("rst_buf_addr", int'(bus.buf_addr), 0);
    check_output("rst_buf_data", int'(bus.buf_data), 0);
    check_output("rst_filt_a", int'(bus.filt_a), 0);
    check_output("rst_frame_ready", int'(bus.frame_ready), 0);
    check_output("rst_frame_len", int'(bus.frame_len), 0);
    check_output("rst_drop_cnt", int'(bus.drop_cnt), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int len, err_at, r;
    bit ewe;
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.frame_end  = 1'b0;
    bus.frame_err  = 1'b0;
    bus.promisc    = 1'b0;
    bus.n_inhibit  = 1'b1;
    bus.frame_ack  = 1'b0;
    do_reset();

    apply_stimulus(60, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    do_ack();

    apply_stimulus(60, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    apply_stimulus(60, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    do_ack();

    apply_stimulus(10, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    apply_stimulus(1600, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    apply_stimulus(MIN_LEN, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    do_ack();
    apply_stimulus(MAX_LEN, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    do_ack();

    apply_stimulus(20, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    apply_stimulus(30, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check_output("frame_len_hold", int'(bus.frame_len), 20);
    do_ack();
    apply_stimulus(40, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    do_ack();

    apply_stimulus(50, 1'b1, 1'b0, 20, 1'b0, 1'b0);
    apply_stimulus(25, 1'b1, 1'b0, 0, 1'b1, 1'b0);

    apply_stimulus(30, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    do_reset();
    apply_stimulus(30, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    do_ack();

    for (int k = 0; k < 25; k++) begin
      len    = $urandom_range(1, 120);
      r      = $urandom_range(0, 5);
      err_at = 0;
      ewe    = 1'b0;
      if (r == 0 && len >= 2) err_at = $urandom_range(1, len - 1);
      if (r == 1 && len >= 2) ewe = 1'b1;
      apply_stimulus(len, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), err_at, ewe, 1'b0);
      if ($urandom_range(0, 2) != 0) do_ack();
    end
    do_ack();

    for (int k = 0; k < 260; k++) begin
      apply_stimulus(8, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    end
    check_output("drop_cnt_saturated", int'(bus.drop_cnt), 255);

    repeat (4) @(posedge clk);
    check_output("writes_outstanding", exp_addr_q.size(), 0);
    check_output("frames_outstanding", exp_len_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
